// File: rtl/timer_arbiter.sv
// Two-requester arbiter that shares a single up-counter. The winning requester is granted
// for len cycles, then gets a one-cycle done pulse. Ties alternate between the requesters.
module timer_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [DATA_WIDTH-1:0] len0,
  input  logic [DATA_WIDTH-1:0] len1,
  output logic [1:0]            grant,
  output logic [1:0]            done,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] count_reg, count_next;
  logic [DATA_WIDTH-1:0] len_q_reg, len_q_next;
  logic                  owner_reg, owner_next;
  logic                  last_served_reg, last_served_next;

  logic                  sel;
  logic [DATA_WIDTH-1:0] sel_len;
  logic                  in_run;
  logic                  in_done;

  // On a tie, the requester that was not served last wins.
  assign sel     = (req == 2'b11) ? ~last_served_reg : req[1];
  assign sel_len = sel ? len1 : len0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      len_q_reg       <= '0;
      owner_reg       <= 1'b0;
      last_served_reg <= 1'b1;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      len_q_reg       <= len_q_next;
      owner_reg       <= owner_next;
      last_served_reg <= last_served_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    count_next       = count_reg;
    len_q_next       = len_q_reg;
    owner_next       = owner_reg;
    last_served_next = last_served_reg;
    case (state_reg)
      IDLE: begin
        if (req != 2'b00) begin
          owner_next = sel;
          len_q_next = sel_len;
          count_next = '0;
          state_next = (sel_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (req[owner_reg]) begin
          // The final edge loads len_q directly, so an all-ones length finishes without wrapping.
          if (count_reg == len_q_reg - ONE) begin
            count_next = len_q_reg;
            state_next = DONE;
          end else begin
            count_next = count_reg + ONE;
          end
        end else begin
          state_next       = IDLE;
          last_served_next = owner_reg;
        end
      end
      DONE: begin
        state_next       = IDLE;
        last_served_next = owner_reg;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_run  = (state_reg == RUN);
    in_done = (state_reg == DONE);
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_per_req
      assign grant[gi] = in_run  && (owner_reg == 1'(gi));
      assign done[gi]  = in_done && (owner_reg == 1'(gi));
    end
  endgenerate

  assign busy  = (state_reg != IDLE);
  assign count = count_reg;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter. Inputs change 1 time unit after a rising edge, and
// outputs are sampled at that same point, so each check sees the state just registered.
module tb_timer_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] len0 = 8'd0;
  logic [7:0] len1 = 8'd0;
  logic [1:0] grant;
  logic [1:0] done;
  logic       busy;
  logic [7:0] count;

  int compared = 0;
  int mismatched = 0;

  timer_arbiter #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .len0(len0), .len1(len1),
    .grant(grant), .done(done), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] g, input logic [1:0] d,
                         input logic b, input logic [7:0] c);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".done"},  32'(done),  32'(d));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".count"}, 32'(count), 32'(c));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int ramp_bad;

    // Reset state
    step();
    chk_out("reset", 2'b00, 2'b00, 1'b0, 8'd0);
    rst = 1'b0;
    step();
    chk_out("idle_after_reset", 2'b00, 2'b00, 1'b0, 8'd0);
    $display("[reset] outputs cleared, idle holds");

    // Single request, len0=3; changing len0 mid-grant must be ignored
    req = 2'b01; len0 = 8'd3;
    step(); chk_out("s1.c0", 2'b01, 2'b00, 1'b1, 8'd0);
    len0 = 8'd1;
    step(); chk_out("s1.c1", 2'b01, 2'b00, 1'b1, 8'd1);
    step(); chk_out("s1.c2", 2'b01, 2'b00, 1'b1, 8'd2);
    step(); chk_out("s1.done", 2'b00, 2'b01, 1'b1, 8'd3);
    req = 2'b00;
    step(); chk_out("s1.idle", 2'b00, 2'b00, 1'b0, 8'd3);
    $display("[single] req=01 len0=3 granted 3 cycles then done");

    // Both requesting: 0 then 1 then 0 again
    do_reset();
    req = 2'b11; len0 = 8'd2; len1 = 8'd4;
    step(); chk_out("s2.r0c0", 2'b01, 2'b00, 1'b1, 8'd0);
    step(); chk_out("s2.r0c1", 2'b01, 2'b00, 1'b1, 8'd1);
    step(); chk_out("s2.r0done", 2'b00, 2'b01, 1'b1, 8'd2);
    step(); chk_out("s2.gap", 2'b00, 2'b00, 1'b0, 8'd2);
    for (int i = 0; i < 4; i++) begin
      step(); chk_out($sformatf("s2.r1c%0d", i), 2'b10, 2'b00, 1'b1, 8'(i));
    end
    step(); chk_out("s2.r1done", 2'b00, 2'b10, 1'b1, 8'd4);
    step(); chk_out("s2.gap2", 2'b00, 2'b00, 1'b0, 8'd4);
    step(); chk_out("s2.r0again", 2'b01, 2'b00, 1'b1, 8'd0);
    req = 2'b00;
    step(); chk_out("s2.abort", 2'b00, 2'b00, 1'b0, 8'd0);
    $display("[fair] req=11 alternated 0,1,0");

    // Zero length goes straight to DONE
    req = 2'b10; len1 = 8'd0;
    step(); chk_out("s3.done", 2'b00, 2'b10, 1'b1, 8'd0);
    req = 2'b00;
    step(); chk_out("s3.idle", 2'b00, 2'b00, 1'b0, 8'd0);
    $display("[zero] req=10 len1=0 done without grant");

    // Abort at count=4
    req = 2'b01; len0 = 8'd10;
    step(); chk_out("s4.c0", 2'b01, 2'b00, 1'b1, 8'd0);
    repeat (4) step();
    chk_out("s4.c4", 2'b01, 2'b00, 1'b1, 8'd4);
    req = 2'b00;
    step(); chk_out("s4.abort", 2'b00, 2'b00, 1'b0, 8'd4);
    step(); chk_out("s4.after", 2'b00, 2'b00, 1'b0, 8'd4);
    $display("[abort] req[0] dropped at count=4, no done");

    // Asynchronous reset mid-RUN at count=6; fairness restarts with requester 0
    req = 2'b01; len0 = 8'd20;
    step(); repeat (6) step();
    chk_out("s5.c6", 2'b01, 2'b00, 1'b1, 8'd6);
    rst = 1'b1;
    #1;
    chk_out("s5.async", 2'b00, 2'b00, 1'b0, 8'd0);
    step();
    rst = 1'b0; req = 2'b11; len0 = 8'd1; len1 = 8'd1;
    step(); chk_out("s5.first", 2'b01, 2'b00, 1'b1, 8'd0);
    req = 2'b00;
    step();
    $display("[rst_mid_run] outputs cleared immediately, req=11 granted 0");

    // Maximum length, no wrap
    req = 2'b01; len0 = 8'd255;
    step();
    n = 0; ramp_bad = 0;
    while (grant == 2'b01 && n < 300) begin
      if (count != 8'(n)) ramp_bad++;
      n++;
      step();
    end
    chk("s6.cycles", 32'(n), 32'd255);
    chk("s6.ramp_errors", 32'(ramp_bad), 32'd0);
    chk_out("s6.done", 2'b00, 2'b01, 1'b1, 8'd255);
    req = 2'b00;
    step(); chk_out("s6.idle", 2'b00, 2'b00, 1'b0, 8'd255);
    $display("[maxlen] len0=255 granted %0d cycles", n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
